// File: rtl/operand_register_file.sv
// Operand register file feeding the 2:1 operand mux: two registered read ports (A -> in0,
// B -> in1), one synchronous write port, and same-edge write-to-read bypass.
module operand_register_file #(
   parameter int unsigned dataWidth = 8,
   parameter int unsigned addrWidth = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 writeEnable,
   input  logic [addrWidth-1:0] writeAddr,
   input  logic [dataWidth-1:0] writeData,
   input  logic                 readEnable,
   input  logic [addrWidth-1:0] readAddrA,
   input  logic [addrWidth-1:0] readAddrB,
   output logic [dataWidth-1:0] readDataA,
   output logic [dataWidth-1:0] readDataB,
   output logic                 readValid
);

   localparam int unsigned NumRegs = 2 ** addrWidth;

   logic [dataWidth-1:0] r_regs [NumRegs];
   logic [dataWidth-1:0] r_read_data_a;
   logic [dataWidth-1:0] r_read_data_b;
   logic                 r_read_valid;

   logic                 w_bypass_a;
   logic                 w_bypass_b;
   logic [dataWidth-1:0] w_next_a;
   logic [dataWidth-1:0] w_next_b;

   // A read of the register being written this edge must see the new value.
   always_comb begin
      w_bypass_a = writeEnable && (writeAddr == readAddrA);
      w_bypass_b = writeEnable && (writeAddr == readAddrB);
      w_next_a   = w_bypass_a ? writeData : r_regs[readAddrA];
      w_next_b   = w_bypass_b ? writeData : r_regs[readAddrB];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NumRegs; i++) begin
            r_regs[i] <= '0;
         end
      end else if (writeEnable) begin
         r_regs[writeAddr] <= writeData;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_read_data_a <= '0;
         r_read_data_b <= '0;
         r_read_valid  <= 1'b0;
      end else begin
         r_read_valid <= readEnable;
         if (readEnable) begin
            r_read_data_a <= w_next_a;
            r_read_data_b <= w_next_b;
         end
      end
   end

   assign readDataA = r_read_data_a;
   assign readDataB = r_read_data_b;
   assign readValid = r_read_valid;

endmodule

// File: tb/tb_operand_register_file.sv
// Directed self-checking bench for operand_register_file, including a bench-side 2:1 mux
// model standing in for the downstream operand multiplexer.
module tb_operand_register_file;

   logic       clk;
   logic       reset_n;
   logic       write_enable;
   logic [1:0] write_addr;
   logic [7:0] write_data;
   logic       read_enable;
   logic [1:0] read_addr_a;
   logic [1:0] read_addr_b;
   logic [7:0] read_data_a;
   logic [7:0] read_data_b;
   logic       read_valid;

   int n_checks;
   int n_errors;

   operand_register_file #(
      .dataWidth(8),
      .addrWidth(2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .writeEnable(write_enable),
      .writeAddr  (write_addr),
      .writeData  (write_data),
      .readEnable (read_enable),
      .readAddrA  (read_addr_a),
      .readAddrB  (read_addr_b),
      .readDataA  (read_data_a),
      .readDataB  (read_data_b),
      .readValid  (read_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, then sample 1 time unit after the rising edge.
   task automatic cyc(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                      input logic re, input logic [1:0] ra, input logic [1:0] rb);
      write_enable = we;
      write_addr   = wa;
      write_data   = wd;
      read_enable  = re;
      read_addr_a  = ra;
      read_addr_b  = rb;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] mux_out(input logic sel);
      return sel ? read_data_b : read_data_a;
   endfunction

   logic [7:0] stream_exp [4];

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      reset_n      = 1'b0;
      write_enable = 1'b0;
      write_addr   = '0;
      write_data   = '0;
      read_enable  = 1'b0;
      read_addr_a  = '0;
      read_addr_b  = '0;
      #12;
      check_eq("rst_a", read_data_a, 8'h00);
      check_eq("rst_b", read_data_b, 8'h00);
      check_eq("rst_valid", read_valid, 1'b0);
      reset_n = 1'b1;

      // Reset clears state asynchronously.
      cyc(1'b1, 2'd1, 8'hFF, 1'b1, 2'd1, 2'd1);
      check_eq("pre_rst_a", read_data_a, 8'hFF);
      check_eq("pre_rst_valid", read_valid, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("async_rst_a", read_data_a, 8'h00);
      check_eq("async_rst_b", read_data_b, 8'h00);
      check_eq("async_rst_valid", read_valid, 1'b0);
      // Hold reset across an edge with a write and read presented: both discarded.
      write_enable = 1'b1;
      write_addr   = 2'd2;
      write_data   = 8'hEE;
      read_enable  = 1'b1;
      read_addr_a  = 2'd2;
      @(posedge clk);
      #1;
      check_eq("rst_hold_a", read_data_a, 8'h00);
      check_eq("rst_hold_valid", read_valid, 1'b0);
      #2 reset_n = 1'b1;
      cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2);
      check_eq("post_rst_reg1", read_data_a, 8'h00);
      check_eq("post_rst_reg2", read_data_b, 8'h00);
      check_eq("post_rst_valid", read_valid, 1'b1);

      // Write then read.
      cyc(1'b1, 2'd2, 8'hAA, 1'b0, 2'd0, 2'd0);
      check_eq("wr_valid_low", read_valid, 1'b0);
      cyc(1'b1, 2'd3, 8'h55, 1'b0, 2'd0, 2'd0);
      cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3);
      check_eq("rd_a_reg2", read_data_a, 8'hAA);
      check_eq("rd_b_reg3", read_data_b, 8'h55);
      check_eq("rd_valid", read_valid, 1'b1);
      cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0);
      check_eq("rd_valid_one_cycle", read_valid, 1'b0);
      check_eq("rd_idle_hold_a", read_data_a, 8'hAA);

      // Bypass on both ports, then one port only.
      cyc(1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 2'd0);
      cyc(1'b1, 2'd1, 8'h3C, 1'b1, 2'd1, 2'd1);
      check_eq("byp_a", read_data_a, 8'h3C);
      check_eq("byp_b", read_data_b, 8'h3C);
      cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd3);
      check_eq("byp_stored", read_data_a, 8'h3C);
      check_eq("byp_other", read_data_b, 8'h55);
      cyc(1'b1, 2'd0, 8'h77, 1'b1, 2'd0, 2'd2);
      check_eq("byp_only_a", read_data_a, 8'h77);
      check_eq("byp_not_b", read_data_b, 8'hAA);

      // Hold: write to the held address does not disturb outputs.
      cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2);
      check_eq("hold_pre_a", read_data_a, 8'hAA);
      cyc(1'b1, 2'd2, 8'h00, 1'b0, 2'd2, 2'd2);
      check_eq("hold_a", read_data_a, 8'hAA);
      check_eq("hold_b", read_data_b, 8'hAA);
      check_eq("hold_valid", read_valid, 1'b0);
      cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd0);
      check_eq("hold_reread", read_data_a, 8'h00);
      check_eq("hold_reread_b", read_data_b, 8'h77);

      // Mux integration.
      cyc(1'b1, 2'd0, 8'hFF, 1'b0, 2'd0, 2'd0);
      cyc(1'b1, 2'd1, 8'h00, 1'b0, 2'd0, 2'd0);
      cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd1);
      check_eq("mux_sel0", mux_out(1'b0), 8'hFF);
      check_eq("mux_sel1", mux_out(1'b1), 8'h00);
      cyc(1'b1, 2'd1, 8'hAA, 1'b0, 2'd0, 2'd1);
      cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd1);
      check_eq("mux_sel1_new", mux_out(1'b1), 8'hAA);
      check_eq("mux_sel0_keep", mux_out(1'b0), 8'hFF);

      // Streaming: reg0=FF reg1=AA reg2=C3 reg3=55.
      cyc(1'b1, 2'd2, 8'hC3, 1'b0, 2'd0, 2'd0);
      stream_exp[0] = 8'hFF;
      stream_exp[1] = 8'hAA;
      stream_exp[2] = 8'hC3;
      stream_exp[3] = 8'h55;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'(i), 2'(3 - i));
         check_eq($sformatf("stream_a%0d", i), read_data_a, stream_exp[i]);
         check_eq($sformatf("stream_b%0d", i), read_data_b, stream_exp[3-i]);
         check_eq($sformatf("stream_valid%0d", i), read_valid, 1'b1);
      end
      cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0);
      check_eq("stream_end_valid", read_valid, 1'b0);
      check_eq("stream_end_hold", read_data_a, 8'h55);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
